// File: rtl/reg_periph_pkg.sv
// Shared types and constants for the register-bus peripheral mux.
package reg_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Upper half of the read word returned for bad selects and timeouts.
  localparam logic [31:0] ERR_RDATA_BASE = 32'hDEAD_0000;

endpackage

// File: rtl/reg_periph_mux.sv
// Register-bus fan-out: routes one upstream request to a selected downstream
// channel, waits for its ack (bounded by a timeout) and returns a one-cycle
// upstream ack. Bad selects and timeouts answer with a tagged error word and
// latch a sticky error status.
module reg_periph_mux
  import reg_periph_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned AW     = 9,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned TMO    = 255
) (
  input  logic                   app_clk,
  input  logic                   app_rst,
  input  logic                   reg_cs,
  input  logic                   reg_wr,
  input  logic [AW-1:0]          reg_addr,
  input  logic [31:0]            reg_wdata,
  input  logic [3:0]             reg_be,
  output logic [31:0]            reg_rdata,
  output logic                   reg_ack,
  output logic [NUM_CH-1:0]      ch_cs,
  output logic                   ch_wr,
  output logic [AW-SEL_W-1:0]    ch_addr,
  output logic [31:0]            ch_wdata,
  output logic [3:0]             ch_be,
  input  logic [NUM_CH*32-1:0]   ch_rdata,
  input  logic [NUM_CH-1:0]      ch_ack,
  input  logic                   err_clr,
  output logic                   err_sticky,
  output logic [2:0]             err_ch
);

  localparam int unsigned    CW       = $clog2(TMO + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TMO - 1);
  localparam logic [SEL_W:0] NCH      = (SEL_W + 1)'(NUM_CH);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [AW-SEL_W-1:0]   addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [2:0]            err_ch_q, err_ch_d;

  logic [SEL_W-1:0]      sel_in;
  logic                  sel_ok;
  logic                  sel_ack;
  logic [31:0]           sel_rdata;
  logic                  err_evt;
  logic [SEL_W-1:0]      err_sel;

  function automatic logic [31:0] err_word(input logic [SEL_W-1:0] s);
    return ERR_RDATA_BASE | {24'h0, 8'(s)};
  endfunction

  assign sel_in = reg_addr[AW-1 -: SEL_W];
  assign sel_ok = ({1'b0, sel_in} < NCH);

  // Selected-channel view: one-hot select during ACCESS, ack/rdata of the selected channel only.
  always_comb begin
    ch_cs     = '0;
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ch_cs[i]  = (state_q == ST_ACCESS);
        sel_ack   = ch_ack[i];
        sel_rdata = ch_rdata[32*i +: 32];
      end
    end
  end

  // Next-state, request latching, response capture and sticky error update.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    err_ch_d = err_ch_q;
    err_evt  = 1'b0;
    err_sel  = sel_q;

    case (state_q)
      ST_IDLE: begin
        if (reg_cs) begin
          wr_d    = reg_wr;
          addr_d  = reg_addr[AW-SEL_W-1:0];
          wdata_d = reg_wdata;
          be_d    = reg_be;
          sel_d   = sel_in;
          cnt_d   = '0;
          if (sel_ok) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_RESP;
            err_evt = 1'b1;
            err_sel = sel_in;
            rdata_d = err_word(sel_in);
          end
        end
      end
      ST_ACCESS: begin
        // Ack is checked before the timeout so an ack on the last cycle still wins.
        if (sel_ack) begin
          rdata_d = sel_rdata;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_evt = 1'b1;
          rdata_d = err_word(sel_q);
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        // Two RESP cycles: the first arms the registered ack, the second shows it.
        if (!ack_q) begin
          ack_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_evt && (!err_q || err_clr)) begin
      err_d    = 1'b1;
      err_ch_d = 3'(err_sel);
    end else if (err_clr && !err_evt) begin
      err_d    = 1'b0;
      err_ch_d = '0;
    end
  end

  // State register.
  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, counter, response and error registers.
  always_ff @(posedge app_clk or posedge app_rst) begin
    if (app_rst) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      err_ch_q <= '0;
    end else begin
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      err_ch_q <= err_ch_d;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_ack    = ack_q;
  assign ch_wr      = wr_q;
  assign ch_addr    = addr_q;
  assign ch_wdata   = wdata_q;
  assign ch_be      = be_q;
  assign err_sticky = err_q;
  assign err_ch     = err_ch_q;

endmodule

// File: tb/tb_reg_periph_mux.sv
// Directed bench for reg_periph_mux with a transaction-level expectation model
// and a per-cycle compare process.
module tb_reg_periph_mux;

  localparam int NUM_CH = 4;
  localparam int AW     = 9;
  localparam int SEL_W  = 3;
  localparam int TMO    = 8;

  logic          app_clk   = 1'b0;
  logic          app_rst   = 1'b1;
  logic          reg_cs    = 1'b0;
  logic          reg_wr    = 1'b0;
  logic [8:0]    reg_addr  = '0;
  logic [31:0]   reg_wdata = '0;
  logic [3:0]    reg_be    = '0;
  logic [31:0]   reg_rdata;
  logic          reg_ack;
  logic [3:0]    ch_cs;
  logic          ch_wr;
  logic [5:0]    ch_addr;
  logic [31:0]   ch_wdata;
  logic [3:0]    ch_be;
  logic [127:0]  ch_rdata  = '0;
  logic [3:0]    ch_ack    = '0;
  logic          err_clr   = 1'b0;
  logic          err_sticky;
  logic [2:0]    err_ch;

  reg_periph_mux #(
    .NUM_CH(NUM_CH),
    .AW    (AW),
    .SEL_W (SEL_W),
    .TMO   (TMO)
  ) dut (
    .app_clk   (app_clk),
    .app_rst   (app_rst),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .ch_cs     (ch_cs),
    .ch_wr     (ch_wr),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_be     (ch_be),
    .ch_rdata  (ch_rdata),
    .ch_ack    (ch_ack),
    .err_clr   (err_clr),
    .err_sticky(err_sticky),
    .err_ch    (err_ch)
  );

  always #5 app_clk = ~app_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected outputs for the current cycle, maintained by the stimulus tasks.
  logic [3:0]  exp_cs    = '0;
  logic        exp_ack   = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;
  logic [2:0]  exp_errch = '0;
  logic        exp_wr    = 1'b0;
  logic [5:0]  exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_be    = '0;
  bit          chk_en    = 1'b0;

  // Observations of DUT behaviour used by the literal pins.
  int          ack_pulses = 0;
  int          cs_cycles  = 0;
  logic [3:0]  last_cs    = '0;
  logic [5:0]  last_addr  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  // Sticky error rule: first error records its channel, clear drops it, error beats clear.
  task automatic err_model(input bit evt, input int sel, input bit clr);
    if (evt && (!exp_err || clr)) begin
      exp_err   = 1'b1;
      exp_errch = 3'(sel);
    end else if (clr && !evt) begin
      exp_err   = 1'b0;
      exp_errch = '0;
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge app_clk) begin
    if (chk_en) begin
      chk("ch_cs",      32'(ch_cs),      32'(exp_cs));
      chk("reg_ack",    32'(reg_ack),    32'(exp_ack));
      chk("reg_rdata",  reg_rdata,       exp_rdata);
      chk("err_sticky", 32'(err_sticky), 32'(exp_err));
      chk("err_ch",     32'(err_ch),     32'(exp_errch));
      chk("ch_wr",      32'(ch_wr),      32'(exp_wr));
      chk("ch_addr",    32'(ch_addr),    32'(exp_addr));
      chk("ch_wdata",   ch_wdata,        exp_wdata);
      chk("ch_be",      32'(ch_be),      32'(exp_be));
      if (reg_ack === 1'b1) ack_pulses++;
      if (ch_cs != 4'b0000) begin
        cs_cycles++;
        last_cs   = ch_cs;
        last_addr = ch_addr;
      end
    end
  end

  // One upstream transaction. ack_at = ACCESS cycle index at which the slave
  // acks (negative = never); spur raises ch_ack[3] in the first ACCESS cycle;
  // clr drives err_clr in the request cycle.
  task automatic xfer(input bit wr, input logic [8:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int ack_at, input logic [31:0] rd,
                      input bit spur, input bit clr);
    int          sel;
    bit          valid;
    bit          evt;
    logic [31:0] res;
    sel   = int'(addr[8:6]);
    valid = (sel < NUM_CH);
    res   = 32'hDEAD_0000 | 32'(sel);
    evt   = 1'b1;

    reg_cs    = 1'b1;
    reg_wr    = wr;
    reg_addr  = addr;
    reg_wdata = wd;
    reg_be    = be;
    err_clr   = clr;
    tick();
    err_clr   = 1'b0;
    reg_wdata = $urandom();
    reg_be    = 4'($urandom());
    exp_wr    = wr;
    exp_addr  = addr[5:0];
    exp_wdata = wd;
    exp_be    = be;

    if (!valid) begin
      exp_rdata = res;
      err_model(1'b1, sel, clr);
    end else begin
      err_model(1'b0, sel, clr);
      for (int k = 0; k < TMO; k++) begin
        exp_cs   = 4'(1 << sel);
        ch_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        ch_ack   = '0;
        if (spur && k == 0) ch_ack[3] = 1'b1;
        if (k == ack_at) begin
          ch_ack[sel] = 1'b1;
          ch_rdata[32*sel +: 32] = rd;
        end
        tick();
        ch_ack = '0;
        if (k == ack_at) begin
          res = rd;
          evt = 1'b0;
          break;
        end
      end
      exp_cs    = '0;
      exp_rdata = res;
      err_model(evt, sel, 1'b0);
    end
    tick();
    exp_ack = 1'b1;
    tick();
    exp_ack = 1'b0;
    reg_cs  = 1'b0;
    tick();
  endtask

  initial begin
    int p_ack;
    int p_cs;
    chk_en = 1'b1;
    tick();
    tick();
    app_rst = 1'b0;
    tick();
    chk("rst_rdata", reg_rdata, 32'h0);
    chk("rst_ack",   32'(reg_ack), 32'h0);
    chk("rst_err",   32'(err_sticky), 32'h0);

    // Read on ch2, slave acks in the third ACCESS cycle.
    p_ack = ack_pulses; p_cs = cs_cycles;
    xfer(1'b0, 9'h085, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0, 1'b0);
    chk("pin_ch2_cs",    32'(last_cs), 32'h4);
    chk("pin_ch2_addr",  32'(last_addr), 32'h05);
    chk("pin_ch2_rdata", reg_rdata, 32'h1234_5678);
    chk("pin_ch2_acks",  32'(ack_pulses - p_ack), 32'd1);
    chk("pin_ch2_cslen", 32'(cs_cycles - p_cs), 32'd3);

    // Write on ch0 with partial byte enables, immediate ack.
    xfer(1'b1, 9'h00A, 32'hCAFE_F00D, 4'b0101, 0, 32'h0BAD_BEEF, 1'b0, 1'b0);
    chk("pin_wr_rdata", reg_rdata, 32'h0BAD_BEEF);

    // Spurious ack from ch3 while ch0 is selected.
    xfer(1'b0, 9'h011, 32'h0, 4'hF, 3, 32'hA5A5_0000, 1'b1, 1'b0);
    chk("pin_spur_rdata", reg_rdata, 32'hA5A5_0000);

    // Ack on the final allowed ACCESS cycle.
    xfer(1'b0, 9'h0FF, 32'h0, 4'hF, TMO - 1, 32'h7777_8888, 1'b0, 1'b0);
    chk("pin_edge_rdata", reg_rdata, 32'h7777_8888);
    chk("pin_edge_err",   32'(err_sticky), 32'h0);

    // Select beyond NUM_CH.
    p_ack = ack_pulses; p_cs = cs_cycles;
    xfer(1'b0, 9'h145, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    chk("pin_sel5_rdata", reg_rdata, 32'hDEAD_0005);
    chk("pin_sel5_err",   32'(err_sticky), 32'h1);
    chk("pin_sel5_errch", 32'(err_ch), 32'h5);
    chk("pin_sel5_nocs",  32'(cs_cycles - p_cs), 32'd0);
    chk("pin_sel5_acks",  32'(ack_pulses - p_ack), 32'd1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_model(1'b0, 0, 1'b1);
    chk("pin_clr_err", 32'(err_sticky), 32'h0);

    // Silent ch1 times out.
    p_cs = cs_cycles;
    xfer(1'b0, 9'h07F, 32'h0, 4'hF, -1, 32'h0, 1'b0, 1'b0);
    chk("pin_tmo_cslen", 32'(cs_cycles - p_cs), 32'd8);
    chk("pin_tmo_rdata", reg_rdata, 32'hDEAD_0001);
    chk("pin_tmo_errch", 32'(err_ch), 32'h1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_model(1'b0, 0, 1'b1);

    // Error in the same cycle as err_clr sets the flag; a later error keeps err_ch.
    xfer(1'b0, 9'h1A0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b1);
    chk("pin_errclr_err",   32'(err_sticky), 32'h1);
    chk("pin_errclr_errch", 32'(err_ch), 32'h6);
    xfer(1'b0, 9'h1C0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    chk("pin_sel7_rdata", reg_rdata, 32'hDEAD_0007);
    chk("pin_sel7_errch", 32'(err_ch), 32'h6);

    // Reset in the middle of an ACCESS to ch0, then a late ack.
    reg_cs   = 1'b1;
    reg_wr   = 1'b0;
    reg_addr = 9'h003;
    reg_be   = 4'hF;
    tick();
    exp_wr    = 1'b0;
    exp_addr  = 6'h03;
    exp_wdata = reg_wdata;
    exp_be    = 4'hF;
    exp_cs    = 4'b0001;
    tick();
    #2;
    app_rst = 1'b1;
    #1;
    chk("pin_rst_cs_now",  32'(ch_cs), 32'h0);
    chk("pin_rst_ack_now", 32'(reg_ack), 32'h0);
    exp_cs = '0; exp_ack = 1'b0; exp_rdata = '0; exp_err = 1'b0; exp_errch = '0;
    exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    reg_cs = 1'b0;
    p_ack  = ack_pulses;
    tick();
    app_rst = 1'b0;
    ch_ack  = 4'b0001;
    ch_rdata[31:0] = 32'h1111_2222;
    tick();
    tick();
    ch_ack = '0;
    tick();
    chk("pin_rst_noack", 32'(ack_pulses - p_ack), 32'd0);
    chk("pin_rst_rdata", reg_rdata, 32'h0);

    // Normal access after reset.
    xfer(1'b0, 9'h0C4, 32'h0, 4'hF, 1, 32'h0F0F_1234, 1'b0, 1'b0);
    chk("pin_post_rdata", reg_rdata, 32'h0F0F_1234);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_periph_mux.md
REG_PERIPH_MUX -- requirements
Module: reg_periph_mux

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, meaning the number of downstream peripheral channels (legal 1..8).
REQ-002 The module SHALL have parameter AW, default 9, meaning the upstream address width.
REQ-003 The module SHALL have parameter SEL_W, default 3, meaning the number of top address bits used as channel select.
REQ-004 The module SHALL have parameter TMO, default 255, meaning the maximum number of cycles to wait for a channel ack (legal 1..65535).
REQ-005 Data width SHALL be fixed at 32 bits and byte-enable width at 4 bits.
REQ-006 The module SHALL use one clock and an asynchronous, active-high reset, as in the port list below.
REQ-007 app_clk  in  1  sole clock.
REQ-008 app_rst  in  1  asynchronous active-high reset.
REQ-009 reg_cs  in  1  upstream request, held until reg_ack.
REQ-010 reg_wr, reg_addr, reg_wdata, reg_be  in  1/AW/32/4  upstream write flag, address, write data, byte enables.
REQ-011 reg_rdata, reg_ack  out  32/1  upstream read data and one-cycle acknowledge.
REQ-012 ch_cs  out  NUM_CH  one-hot downstream selects.
REQ-013 ch_wr, ch_addr, ch_wdata, ch_be  out  1/AW-SEL_W/32/4  shared downstream request fields.
REQ-014 ch_rdata, ch_ack  in  NUM_CH*32/NUM_CH  per-channel read data (channel i at bits 32i+31:32i) and ack.
REQ-015 err_clr  in  1  clears the sticky error status.
REQ-016 err_sticky, err_ch  out  1/3  sticky error flag and channel index of the first error.

Function
REQ-017 Channel index sel SHALL be reg_addr[AW-1:AW-SEL_W]; ch_addr SHALL be reg_addr[AW-SEL_W-1:0], latched.
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-019 In IDLE with reg_cs=1 the module SHALL latch reg_wr/addr/wdata/be and sel; if sel<NUM_CH it SHALL enter ACCESS, else it SHALL enter RESP with an error.
REQ-020 In ACCESS, ch_cs[sel] SHALL be 1 and all other ch_cs bits 0; ch_ack bits of unselected channels SHALL be ignored.
REQ-021 When ch_ack[sel]=1 is sampled in ACCESS, the module SHALL capture ch_rdata[sel], drop ch_cs and enter RESP.
REQ-022 A timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; reaching TMO without ack SHALL drop ch_cs and enter RESP with an error.
REQ-023 An ack sampled in the same cycle the counter reaches TMO SHALL take precedence, giving a normal response.
REQ-024 In RESP, reg_ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; reg_ack SHALL be 0 in all other states.
REQ-025 reg_ack SHALL rise the cycle after the ack-sampling edge, giving a minimum of 3 cycles from reg_cs sampled to reg_ack.
REQ-026 Error response reg_rdata SHALL be 32'hDEAD_0000 OR'd with the 8-bit zero-extended sel.
REQ-027 Write data SHALL reach the channel unchanged, and the upstream response for writes SHALL be the same as for reads.
REQ-028 reg_rdata SHALL hold its value after reg_ack until the next response.
REQ-029 On an error with err_sticky=0, the module SHALL set err_sticky=1 and err_ch=sel[2:0]; further errors SHALL NOT overwrite err_ch.
REQ-030 err_clr=1 SHALL clear err_sticky and err_ch next cycle; an error in the same cycle SHALL win.
REQ-031 reg_cs changes outside IDLE SHALL be ignored; no request queueing.

Reset
REQ-032 app_rst=1 SHALL immediately force state IDLE and clear ch_cs, reg_ack, reg_rdata, ch_wr, ch_addr, ch_wdata, ch_be, the counter, err_sticky and err_ch.
REQ-033 A reset mid-ACCESS SHALL abort the transfer with no reg_ack; an ack arriving after reset SHALL be ignored.

Structure
REQ-034 Package reg_periph_pkg SHALL hold the FSM state enum and the ERR_RDATA_BASE constant (32'hDEAD_0000).
REQ-035 The block SHALL be a single module with no sub-modules; the counter width SHALL be $clog2(TMO+1).

Verification
REQ-036 The bench SHALL cover a read on ch2 (addr 9'h085) where the slave acks after 2 cycles with 32'h1234_5678: ch_cs=4'b0100, ch_addr=6'h05, and reg_rdata=32'h1234_5678 with one reg_ack pulse.
REQ-037 The bench SHALL cover an access to sel=5 with NUM_CH=4: no ch_cs, reg_ack 2 cycles later, reg_rdata=32'hDEAD_0005, err_sticky=1, err_ch=5.
REQ-038 The bench SHALL cover a silent ch1 with TMO=8: ch_cs[1] high for 8 cycles, then reg_rdata=32'hDEAD_0001 and err_ch=1.
REQ-039 The bench SHALL cover ack at exactly the TMO cycle: normal data is returned and err_sticky stays 0.
REQ-040 The bench SHALL cover a spurious ch_ack[3] during an access to ch0: it is ignored and ch0 data is returned.
REQ-041 The bench SHALL cover app_rst pulsed mid-ACCESS: ch_cs=0 immediately, no reg_ack, and a new access after reset completes normally.
